// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer controller.
//   SLOTS  : slots per TDM frame
//   SEL_W  : width of the slot index / demux select
//   MISS_W : width of the consecutive-missed-sync counter
//   state_e: frame-alignment state (hunting for sync, or locked)
package tdm_pkg;

  localparam int unsigned SLOTS  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned MISS_W = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage : tdm_pkg

// File: rtl/tdm_demux.sv
// 1-to-SLOTS demultiplexer: routes din_i to the output selected by sel_i,
// all other outputs low. With din_i tied high it yields a one-hot decode.
//   din_i  : data input
//   sel_i  : output select
//   dout_o : demuxed outputs, dout_o[n] = din_i when sel_i == n
module tdm_demux
  import tdm_pkg::*;
(
  input  logic             din_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [SLOTS-1:0] dout_o
);

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_out
    assign dout_o[gi] = din_i & (sel_i == SEL_W'(gi));
  end

endmodule : tdm_demux

// File: rtl/tdm_demux_ctrl.sv
// TDM demultiplexer controller. Hunts for frame sync, then sequences the
// slot select through each 8-slot frame, assembling the serial bits into a
// parallel word. Missing sync pulses are flywheeled until MAX_MISS
// consecutive misses, at which point lock is dropped.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset
//   d_i     : serial TDM data, one slot per cycle
//   fsync_i : high in the cycle d_i carries slot 0
//   sel_o   : slot index of the bit on d_i this cycle
//   y_o     : last complete frame, y_o[n] = slot n
//   valid_o : one-cycle pulse when y_o is updated
//   lock_o  : high while frame-locked
//   err_o   : one-cycle pulse on a sync seen away from slot 0 while locked
module tdm_demux_ctrl
  import tdm_pkg::*;
#(
  parameter int unsigned MAX_MISS = 3
)
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             d_i,
  input  logic             fsync_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [SLOTS-1:0] y_o,
  output logic             valid_o,
  output logic             lock_o,
  output logic             err_o
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [SLOTS-1:0]    cap_q, cap_d;
  logic [SLOTS-1:0]    y_q, y_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic [SLOTS-1:0]    wr_en;
  logic [MISS_W-1:0]   miss_inc;
  logic [SLOTS-1:0]    cap_wr;

  // One-hot write enable for the capture register, following the slot select.
  tdm_demux u_demux (
    .din_i  (1'b1),
    .sel_i  (cnt_q),
    .dout_o (wr_en)
  );

  assign miss_inc = miss_q + MISS_W'(1);
  // Capture register with the current bit merged into the selected slot.
  assign cap_wr   = (cap_q & ~wr_en) | ({SLOTS{d_i}} & wr_en);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    cap_d   = cap_q;
    y_d     = y_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      HUNT: begin
        // Counter sits at 0 here, so cap_wr writes slot 0.
        if (fsync_i) begin
          cap_d   = cap_wr;
          cnt_d   = SEL_W'(1);
          miss_d  = '0;
          state_d = LOCKED;
        end
      end

      LOCKED: begin
        if (fsync_i && (cnt_q != '0)) begin
          // Sync arrived early: realign on it, drop the partial frame.
          err_d    = 1'b1;
          cap_d[0] = d_i;
          cnt_d    = SEL_W'(1);
          miss_d   = '0;
        end else if ((cnt_q == '0) && !fsync_i &&
                     (miss_inc == MISS_W'(MAX_MISS))) begin
          // Too many consecutive misses: give up and hunt again.
          state_d = HUNT;
          cnt_d   = '0;
          miss_d  = '0;
        end else begin
          cap_d = cap_wr;
          cnt_d = cnt_q + SEL_W'(1);
          if (cnt_q == '0) begin
            // Sync at slot 0 wins over miss counting; absent sync flywheels.
            miss_d = fsync_i ? '0 : miss_inc;
          end
          if (cnt_q == SEL_W'(SLOTS - 1)) begin
            y_d     = {d_i, cap_q[SLOTS-2:0]};
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = HUNT;
        cnt_d   = '0;
        miss_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      miss_q  <= '0;
      cap_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      cap_q   <= cap_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign sel_o   = cnt_q;
  assign y_o     = y_q;
  assign valid_o = valid_q;
  assign lock_o  = (state_q == LOCKED);
  assign err_o   = err_q;

endmodule : tdm_demux_ctrl
